dac_write_sequencer: RTL and testbench

DAC_WRITE_SEQUENCER -- requirements
Module: dac_write_sequencer

---
 rtl/dac_write_sequencer_if.sv | 37 +++
 rtl/dac_write_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_dac_write_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dac_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : dac_write_sequencer_if
// Description : Frame-input handshake plus parallel DAC write bus.
//               The master modport is the sequencer side. It accepts
//               frames and drives the DAC bus. The slave modport is the
//               side that supplies frames and observes the bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface dac_write_sequencer_if #(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_W-1:0] sampleData;
    logic                     sampleValid;
    logic                     sampleReady;
    logic [DATA_W-1:0]        DB;
    logic [CH_W-1:0]          AB;
    logic                     CS;
    logic                     WR;
    logic                     LDAC;
    logic                     CLR;
    logic                     PD;

    modport master (
        input  sampleData, sampleValid,
        output sampleReady, DB, AB, CS, WR, LDAC, CLR, PD
    );

    modport slave (
        output sampleData, sampleValid,
        input  sampleReady, DB, AB, CS, WR, LDAC, CLR, PD
    );
endinterface
`default_nettype wire

// File: rtl/dac_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dac_write_sequencer
// Description : Rate-divided multi-channel parallel DAC writer. On every
//               frame tick it writes each enabled channel. Each write uses
//               SETUP, STROBE and HOLD phases. The frame ends with one
//               shared LDAC pulse. Frames come from a one-deep input buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_write_sequencer #(
    parameter int DATA_W    = 12,
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 16,
    parameter int PHASE_CYC = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  En,
    input  logic [DIV_W-1:0]      rateDiv,
    input  logic [NUM_CH-1:0]     chMask,
    input  logic                  clrFlags,
    dac_write_sequencer_if.master bus,
    output logic                  underrun,
    output logic                  late,
    output logic [15:0]           frameCount,
    output logic                  busy
);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PH_W    = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam int FRAME_W = NUM_CH * DATA_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        LOAD   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic                buf_full_q, buf_full_d;
    logic [FRAME_W-1:0]  buf_data_q, buf_data_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [DATA_W-1:0]   db_q, db_d;
    logic [CH_W-1:0]     ab_q, ab_d;
    logic                cs_q, cs_d;
    logic                wr_q, wr_d;
    logic                ldac_q, ldac_d;
    logic                clr_n_q, clr_n_d;
    logic                underrun_q, underrun_d;
    logic                late_q, late_d;
    logic [15:0]         fcount_q, fcount_d;

    logic                tick;
    logic                frame_start;
    logic                phase_done;
    logic                sample_ready;
    logic                xfer;
    logic [CH_W-1:0]     first_ch;
    logic [CH_W-1:0]     next_ch;
    logic                has_next;

    // Picks one channel's word out of a packed frame.
    function automatic logic [DATA_W-1:0] ch_word(input logic [FRAME_W-1:0] f,
                                                  input logic [CH_W-1:0]    c);
        ch_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (c == CH_W'(i)) ch_word = f[i*DATA_W +: DATA_W];
        end
    endfunction

    // Frame-rate divider. rateDiv is compared live. The wrap also covers
    // rateDiv being lowered below the current count.
    always_comb begin
        cnt_d = cnt_q;
        if (!En)                   cnt_d = '0;
        else if (cnt_q >= rateDiv) cnt_d = '0;
        else                       cnt_d = cnt_q + DIV_W'(1);
    end

    assign tick         = En && (cnt_q == rateDiv);
    assign phase_done   = (ph_q == PH_W'(PHASE_CYC - 1));
    assign sample_ready = clr_n_q && !buf_full_q;
    assign xfer         = bus.sampleValid && sample_ready;

    // Channel search. first_ch is the lowest channel in the live mask. It is
    // used at the tick, when the mask is latched. next_ch is the lowest
    // latched channel above the one being written.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chMask[i]) first_ch = CH_W'(i);
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_ch  = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end

    // Write-sequence FSM: next state, phase timer and frame counter.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        ch_d        = ch_q;
        mask_d      = mask_q;
        fcount_d    = fcount_q;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    frame_start = 1'b1;
                    mask_d      = chMask;
                    if (chMask != '0) begin
                        state_d = SETUP;
                        ch_d    = first_ch;
                    end else begin
                        // An empty mask still counts as a completed frame.
                        fcount_d = fcount_q + 16'd1;
                    end
                end
            end
            SETUP:  if (phase_done) state_d = STROBE;
            STROBE: if (phase_done) state_d = HOLD;
            HOLD: begin
                if (phase_done) begin
                    if (has_next) begin
                        state_d = SETUP;
                        ch_d    = next_ch;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (phase_done) begin
                    state_d  = IDLE;
                    fcount_d = fcount_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) ph_d = phase_done ? '0 : ph_q + PH_W'(1);
    end

    // Input buffer, frame capture, sticky flags and registered bus outputs.
    always_comb begin
        buf_full_d = (buf_full_q && !frame_start) || xfer;
        buf_data_d = xfer ? bus.sampleData : buf_data_q;
        // With an empty buffer the previous frame is kept and re-sent.
        frame_d    = (frame_start && buf_full_q) ? buf_data_q : frame_q;
        underrun_d = (frame_start && !buf_full_q) || (underrun_q && !clrFlags);
        late_d     = (tick && (state_q != IDLE)) || (late_q && !clrFlags);
        clr_n_d    = 1'b1;
        cs_d       = !(state_d inside {SETUP, STROBE, HOLD});
        wr_d       = (state_d != STROBE);
        ldac_d     = (state_d != LOAD);
        ab_d       = ab_q;
        db_d       = db_q;
        // frame_d is used so the first channel sees the data captured at this tick.
        if (state_d == SETUP) begin
            ab_d = ch_d;
            db_d = ch_word(frame_d, ch_d);
        end
    end

    // State and datapath registers. Asynchronous reset forces the bus idle
    // at once. It also suppresses any LDAC pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            ch_q       <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            frame_q    <= '0;
            db_q       <= '0;
            ab_q       <= '0;
            cs_q       <= 1'b1;
            wr_q       <= 1'b1;
            ldac_q     <= 1'b1;
            clr_n_q    <= 1'b0;
            underrun_q <= 1'b0;
            late_q     <= 1'b0;
            fcount_q   <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            ch_q       <= ch_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            frame_q    <= frame_d;
            db_q       <= db_d;
            ab_q       <= ab_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            ldac_q     <= ldac_d;
            clr_n_q    <= clr_n_d;
            underrun_q <= underrun_d;
            late_q     <= late_d;
            fcount_q   <= fcount_d;
        end
    end

    assign bus.sampleReady = sample_ready;
    assign bus.DB          = db_q;
    assign bus.AB          = ab_q;
    assign bus.CS          = cs_q;
    assign bus.WR          = wr_q;
    assign bus.LDAC        = ldac_q;
    assign bus.CLR         = clr_n_q;
    assign bus.PD          = 1'b1;
    assign underrun        = underrun_q;
    assign late            = late_q;
    assign frameCount      = fcount_q;
    assign busy            = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_dac_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_write_sequencer
// Description : Directed self-checking bench for dac_write_sequencer.
//               It uses the default parameters (12-bit data, 2 channels,
//               2-cycle phases). cyc counts rising edges since En was first
//               raised. Checks are made on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_write_sequencer;
    localparam int DATA_W    = 12;
    localparam int NUM_CH    = 2;
    localparam int DIV_W     = 16;
    localparam int PHASE_CYC = 2;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              En;
    logic [DIV_W-1:0]  rateDiv;
    logic [NUM_CH-1:0] chMask;
    logic              clrFlags;
    logic              underrun;
    logic              late;
    logic [15:0]       frameCount;
    logic              busy;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    dac_write_sequencer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dif ();

    dac_write_sequencer #(
        .DATA_W   (DATA_W),
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .PHASE_CYC(PHASE_CYC)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .En        (En),
        .rateDiv   (rateDiv),
        .chMask    (chMask),
        .clrFlags  (clrFlags),
        .bus       (dif),
        .underrun  (underrun),
        .late      (late),
        .frameCount(frameCount),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the write strobes and the address/data bus together.
    task automatic chk_bus(input string tag, input logic cs, input logic wr,
                           input logic ldac, input logic [31:0] ab, input logic [31:0] db);
        chk({tag, ".CS"},   dif.CS,   cs);
        chk({tag, ".WR"},   dif.WR,   wr);
        chk({tag, ".LDAC"}, dif.LDAC, ldac);
        chk({tag, ".AB"},   dif.AB,   ab);
        chk({tag, ".DB"},   dif.DB,   db);
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(negedge Clk);
            cyc++;
        end
    endtask

    initial begin
        Rst = 1'b0; En = 1'b0; rateDiv = 16'd99; chMask = '0; clrFlags = 1'b0;
        dif.sampleValid = 1'b0; dif.sampleData = '0;

        // Asynchronous reset takes effect before the first clock edge.
        #2 Rst = 1'b1;
        #1;
        chk_bus("rst", 1'b1, 1'b1, 1'b1, 0, 0);
        chk("rst.CLR",      dif.CLR, 1'b0);
        chk("rst.PD",       dif.PD, 1'b1);
        chk("rst.ready",    dif.sampleReady, 1'b0);
        chk("rst.underrun", underrun, 1'b0);
        chk("rst.late",     late, 1'b0);
        chk("rst.fcount",   frameCount, 16'd0);
        chk("rst.busy",     busy, 1'b0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("rel.CLR_noedge", dif.CLR, 1'b0);
        @(negedge Clk);
        chk("rel.CLR",   dif.CLR, 1'b1);
        chk("rel.ready", dif.sampleReady, 1'b1);

        // Frame 1: both channels, fresh data, frame period 100 clocks.
        En = 1'b1; chMask = 2'b11; cyc = 0;
        dif.sampleData = {12'hABC, 12'h123}; dif.sampleValid = 1'b1;
        goto(1);
        chk("f1.ready_full", dif.sampleReady, 1'b0);
        dif.sampleValid = 1'b0;
        goto(99);  chk_bus("f1.pre",     1, 1, 1, 0, 0); chk("f1.pre.busy", busy, 0);
        goto(100); chk_bus("f1.setup0",  0, 1, 1, 0, 12'h123);
                   chk("f1.ready_empty", dif.sampleReady, 1'b1); chk("f1.busy", busy, 1);
        goto(102); chk_bus("f1.strobe0", 0, 0, 1, 0, 12'h123);
        goto(103); chk_bus("f1.strobe0b",0, 0, 1, 0, 12'h123);
        goto(104); chk_bus("f1.hold0",   0, 1, 1, 0, 12'h123);
        goto(106); chk_bus("f1.setup1",  0, 1, 1, 1, 12'hABC);
        goto(108); chk_bus("f1.strobe1", 0, 0, 1, 1, 12'hABC);
        goto(112); chk_bus("f1.load",    1, 1, 0, 1, 12'hABC);
        goto(113); chk_bus("f1.load_b",  1, 1, 0, 1, 12'hABC);
        chk("f1.fc_in_load", frameCount, 16'd0);
        goto(114); chk_bus("f1.idle",    1, 1, 1, 1, 12'hABC);
        chk("f1.fc", frameCount, 16'd1); chk("f1.idle.busy", busy, 0);
        chk("f1.underrun", underrun, 0);

        // Frame 2: no new data, so the previous frame is re-sent.
        goto(199); chk("f2.pre.underrun", underrun, 0); chk("f2.pre.CS", dif.CS, 1);
        goto(200); chk("f2.underrun", underrun, 1); chk_bus("f2.setup0", 0, 1, 1, 0, 12'h123);
        goto(206); chk_bus("f2.setup1", 0, 1, 1, 1, 12'hABC);
        goto(214); chk("f2.fc", frameCount, 16'd2);
        goto(220); clrFlags = 1'b1;
        goto(221); clrFlags = 1'b0; chk("f2.clr.underrun", underrun, 0);

        // Frame 3: only channel 1 enabled, new data.
        chMask = 2'b10; dif.sampleData = {12'h5A5, 12'h0F0}; dif.sampleValid = 1'b1;
        goto(222); dif.sampleValid = 1'b0; chk("f3.ready_full", dif.sampleReady, 0);
        goto(300); chk_bus("f3.setup1",  0, 1, 1, 1, 12'h5A5); chk("f3.underrun", underrun, 0);
        goto(302); chk_bus("f3.strobe1", 0, 0, 1, 1, 12'h5A5);
        goto(305); chk_bus("f3.hold1",   0, 1, 1, 1, 12'h5A5);
        goto(306); chk_bus("f3.load",    1, 1, 0, 1, 12'h5A5);
        goto(308); chk("f3.fc", frameCount, 16'd3); chk("f3.busy", busy, 0);

        // Empty mask: no bus activity, but the frame is still counted.
        goto(310); chMask = 2'b00;
        goto(399); chk("f4.pre.fc", frameCount, 16'd3);
        goto(400); chk("f4.fc", frameCount, 16'd4); chk("f4.busy", busy, 0);
                   chk("f4.CS", dif.CS, 1);
        goto(401); chk("f4.CS_b", dif.CS, 1); chk("f4.LDAC", dif.LDAC, 1);
        goto(405); clrFlags = 1'b1;
        goto(406); clrFlags = 1'b0; chMask = 2'b11;
        chk("f4.clr.underrun", underrun, 0); chk("f4.clr.late", late, 0);

        // En dropped during SETUP of ch0: the frame still completes.
        goto(500); chk_bus("f5.setup0", 0, 1, 1, 0, 12'h0F0); En = 1'b0;
        goto(506); chk_bus("f5.setup1", 0, 1, 1, 1, 12'h5A5);
        goto(512); chk_bus("f5.load",   1, 1, 0, 1, 12'h5A5);
        goto(514); chk("f5.fc", frameCount, 16'd5); chk("f5.busy", busy, 0);
        goto(620); chk("f5.quiet.CS", dif.CS, 1); chk("f5.quiet.fc", frameCount, 16'd5);

        // The counter was held at 0, so the first tick comes exactly 6 clocks
        // after re-enabling. A frame takes 14 clocks, so ticks are dropped.
        En = 1'b1; rateDiv = 16'd5;
        goto(625); chk("r5.pre.CS", dif.CS, 1);
        goto(626); chk_bus("r5.f1.setup0", 0, 1, 1, 0, 12'h0F0);
        goto(631); chk("r5.late0", late, 0);
        goto(632); chk("r5.late1", late, 1); chk_bus("r5.f1.setup1", 0, 1, 1, 1, 12'h5A5);
        goto(639); chk("r5.f1.fc_load", frameCount, 16'd5); chk("r5.f1.LDAC", dif.LDAC, 0);
        goto(640); chk("r5.f1.fc", frameCount, 16'd6); chk("r5.f1.busy", busy, 0);
        goto(643); chk("r5.gap.CS", dif.CS, 1);
        goto(644); chk_bus("r5.f2.setup0", 0, 1, 1, 0, 12'h0F0);
        goto(649); clrFlags = 1'b1;
        goto(650); clrFlags = 1'b0; chk("r5.set_wins", late, 1);
                   chk_bus("r5.f2.setup1", 0, 1, 1, 1, 12'h5A5);
        goto(651); clrFlags = 1'b1;
        goto(652); clrFlags = 1'b0; chk("r5.cleared", late, 0);
        goto(656); chk("r5.late_again", late, 1);
        goto(658); chk("r5.f2.fc", frameCount, 16'd7);
        goto(662); chk_bus("r5.f3.setup0", 0, 1, 1, 0, 12'h0F0);
        goto(664); chk("r5.f3.strobe.WR", dif.WR, 0);

        // Reset during STROBE acts without any clock edge.
        #1 Rst = 1'b1;
        #1;
        chk_bus("mrst", 1, 1, 1, 0, 0);
        chk("mrst.CLR", dif.CLR, 0);     chk("mrst.ready", dif.sampleReady, 0);
        chk("mrst.late", late, 0);       chk("mrst.fc", frameCount, 16'd0);
        chk("mrst.busy", busy, 0);
        @(negedge Clk);
        chk("mrst.hold.LDAC", dif.LDAC, 1);
        Rst = 1'b0;
        #1 chk("mrst.rel.CLR_noedge", dif.CLR, 0);
        @(negedge Clk);
        chk("mrst.rel.CLR", dif.CLR, 1); chk("mrst.rel.ready", dif.sampleReady, 1);
        chk("mrst.rel.LDAC", dif.LDAC, 1); chk("mrst.rel.CS", dif.CS, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
